// File: rtl/arm_prefetch_queue_if.sv
// Fetch-side handshakes: instruction memory request/response and the decode handoff.
// ARM_PREFETCH_ABORT_EN adds the response error flag and the head abort flag.
interface arm_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
`ifdef ARM_PREFETCH_ABORT_EN
  logic                  imem_rsp_err;
  logic                  inst_abort;
`endif

  modport master (
`ifdef ARM_PREFETCH_ABORT_EN
    input  imem_rsp_err,
    output inst_abort,
`endif
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
`ifdef ARM_PREFETCH_ABORT_EN
    output imem_rsp_err,
    input  inst_abort,
`endif
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/arm_prefetch_queue.sv
// In-order instruction prefetch queue with redirect flush; optional ARM_PREFETCH_ABORT_EN.
// Request accept to inst_valid >= 2 cycles; issue throttled by queue credits, decode stalls hold the head.
module arm_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_halt,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  arm_prefetch_queue_if.master  io_bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  // Discard count can accumulate across back-to-back redirects, so it gets headroom.
  localparam int DCW = CW + 2;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_outstanding;
  logic [DCW-1:0]        r_discard;
  logic                  r_stop;
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
`ifdef ARM_PREFETCH_ABORT_EN
  logic                  r_abort_mem [DEPTH];
`endif

  logic          w_rsp_err;
  logic          w_credit_ok;
  logic          w_req_vld;
  logic          w_req_fire;
  logic [PW-1:0] w_iss_ptr;
  logic          w_rsp_drop;
  logic          w_rsp_push;
  logic          w_inflight_dec;
  logic          w_inst_vld;
  logic          w_pop;
  logic          w_head_vld;

`ifdef ARM_PREFETCH_ABORT_EN
  assign w_rsp_err = io_bus.imem_rsp_err;
`else
  assign w_rsp_err = 1'b0;
`endif

  assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
  assign w_req_vld      = !i_rst && !i_halt && !i_redirect_valid && !r_stop && w_credit_ok;
  assign w_req_fire     = w_req_vld && io_bus.imem_req_ready;
  // Issue slot sits just past every queued and in-flight entry, so PCs stay in issue order.
  assign w_iss_ptr      = r_wr_ptr + r_outstanding[PW-1:0];
  assign w_rsp_drop     = io_bus.imem_rsp_valid && (r_discard != '0);
  assign w_rsp_push     = io_bus.imem_rsp_valid && (r_discard == '0) && (r_outstanding != '0)
                          && !i_redirect_valid;
  assign w_inflight_dec = io_bus.imem_rsp_valid && ((r_discard != '0) || (r_outstanding != '0));
  assign w_head_vld     = (r_count != '0);
  assign w_inst_vld     = w_head_vld && !i_redirect_valid;
  assign w_pop          = w_inst_vld && io_bus.inst_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_stop        <= 1'b0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= i_redirect_pc;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= r_discard + DCW'(r_outstanding) - DCW'(w_inflight_dec);
      r_stop        <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_push);
      r_count       <= r_count + CW'(w_rsp_push) - CW'(w_pop);
      if (w_rsp_drop) begin
        r_discard <= r_discard - DCW'(1);
      end
      if (w_rsp_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_rsp_err) begin
          r_stop <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_req_fire) begin
      r_pc_mem[w_iss_ptr] <= r_fetch_pc;
    end
    if (w_rsp_push && !i_rst) begin
      r_data_mem[r_wr_ptr] <= io_bus.imem_rsp_data;
`ifdef ARM_PREFETCH_ABORT_EN
      r_abort_mem[r_wr_ptr] <= w_rsp_err;
`endif
    end
  end

  assign io_bus.imem_req_valid = w_req_vld;
  assign io_bus.imem_addr      = r_fetch_pc;
  assign io_bus.inst_valid     = w_inst_vld;
  assign io_bus.inst           = w_head_vld ? r_data_mem[r_rd_ptr] : '0;
  assign io_bus.inst_pc        = w_head_vld ? r_pc_mem[r_rd_ptr] : '0;
`ifdef ARM_PREFETCH_ABORT_EN
  assign io_bus.inst_abort     = w_head_vld && r_abort_mem[r_rd_ptr];
`endif
endmodule

// File: tb/tb_arm_prefetch_queue.sv
// Bench for arm_prefetch_queue: latency-configurable memory model plus an in-order scoreboard.
module tb_arm_prefetch_queue;
  localparam int        AW    = 32;
  localparam int        DW    = 32;
  localparam int        DEPTH = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt;
  logic          redir;
  logic [AW-1:0] redir_pc;

  arm_prefetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  arm_prefetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_halt(halt), .i_redirect_valid(redir),
    .i_redirect_pc(redir_pc), .io_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic abort; } exp_t;
  typedef struct { logic halt; logic rdy; logic rv; logic [31:0] addr; logic iv; logic [31:0] pc; } vec_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  logic [31:0] pop_hist[$];
  vec_t        vt[14];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          n_req = 0;
  int          n_pop = 0;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory response driver: in-order, each request answered lat cycles after acceptance.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
`ifdef ARM_PREFETCH_ABORT_EN
    bus.imem_rsp_err   = 1'b0;
`endif
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(mq[0].addr);
`ifdef ARM_PREFETCH_ABORT_EN
        bus.imem_rsp_err   = (mq[0].addr == err_addr);
`endif
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
`ifdef ARM_PREFETCH_ABORT_EN
        bus.imem_rsp_err   = 1'b0;
`endif
      end
    end
  end

  // Monitor: handshakes seen mid-cycle take effect at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mq.delete();
      sb.delete();
    end else begin
      if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (redir) sb.delete();
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        n_req++;
        mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
        sb.push_back('{pc: bus.imem_addr, data: mem_data(bus.imem_addr), abort: (bus.imem_addr == err_addr)});
      end
      if (bus.inst_valid && bus.inst_ready) begin
        n_pop++;
        pop_hist.push_back(bus.inst_pc);
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_pop: got unexpected inst_pc 0x%0h, expected no instruction", bus.inst_pc);
        end else begin
          e = sb.pop_front();
          check("sb_inst_pc", bus.inst_pc, e.pc);
          check("sb_inst", bus.inst, e.data);
`ifdef ARM_PREFETCH_ABORT_EN
          check("sb_inst_abort", bus.inst_abort, e.abort);
`endif
        end
      end
    end
  end

  task automatic do_reset(input int l);
    step();
    rst = 1'b1; halt = 1'b0; redir = 1'b0; bus.inst_ready = 1'b0; lat = l;
    step();
    step();
    @(negedge clk);
    check("rst_req_vld", bus.imem_req_valid, 0);
    check("rst_imem_addr", bus.imem_addr, RPC);
    check("rst_inst_vld", bus.inst_valid, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_inst_pc", bus.inst_pc, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int r0, p0, found, bad;
    logic [31:0] first;
    rst = 1'b1; halt = 1'b0; redir = 1'b0; redir_pc = '0;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;

    //           halt rdy  rv  addr          iv  pc
    vt[0]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h110};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h114, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h118, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};
    vt[10] = '{1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 32'h118};
    vt[11] = '{1'b0, 1'b0, 1'b1, 32'h124, 1'b1, 32'h118};
    vt[12] = '{1'b0, 1'b0, 1'b0, 32'h128, 1'b1, 32'h118};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'h128, 1'b1, 32'h118};

    // Streaming with a 1-cycle memory, halt window, then fill to DEPTH
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      halt = vt[i].halt;
      bus.inst_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_req_vld", i), bus.imem_req_valid, vt[i].rv);
      check($sformatf("vec%0d_imem_addr", i), bus.imem_addr, vt[i].addr);
      check($sformatf("vec%0d_inst_vld", i), bus.inst_valid, vt[i].iv);
      if (vt[i].iv) check($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vt[i].pc);
      step();
    end

    // Decode stalled from reset: exactly DEPTH requests, then in-order drain
    do_reset(1);
    r0 = n_req;
    repeat (10) step();
    check("full_req_count", n_req - r0, DEPTH);
    @(negedge clk);
    check("full_req_vld", bus.imem_req_valid, 0);
    check("full_inst_vld", bus.inst_valid, 1);
    check("full_head_pc", bus.inst_pc, 32'h100);
    step();
    p0 = n_pop;
    bus.inst_ready = 1'b1;
    repeat (8) step();
    check("drain_count_ge_depth", (n_pop - p0) >= DEPTH, 1);

    // 3-cycle memory, redirect with two requests in flight
    do_reset(3);
    bus.inst_ready = 1'b1;
    step();
    step();
    redir = 1'b1; redir_pc = 32'h2000;
    @(negedge clk);
    check("redir_req_blocked", bus.imem_req_valid, 0);
    step();
    redir = 1'b0;
    @(negedge clk);
    check("redir_req_vld", bus.imem_req_valid, 1);
    check("redir_imem_addr", bus.imem_addr, 32'h2000);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bus.inst_valid) found = 1;
    end
    check("redir_inst_seen", found, 1);
    check("redir_first_pc", bus.inst_pc, 32'h2000);

    // Halt with two outstanding: both land and drain, nothing new issued
    do_reset(3);
    bus.inst_ready = 1'b1;
    step();
    step();
    halt = 1'b1;
    r0 = n_req;
    p0 = n_pop;
    repeat (10) step();
    check("halt_no_req", n_req - r0, 0);
    check("halt_pops", n_pop - p0, 2);
    @(negedge clk);
    check("halt_inst_vld", bus.inst_valid, 0);
    check("halt_req_vld", bus.imem_req_valid, 0);
    step();
    halt = 1'b0;

    // Back-to-back redirects: last target wins
    do_reset(2);
    bus.inst_ready = 1'b1;
    repeat (6) step();
    p0 = pop_hist.size();
    redir = 1'b1; redir_pc = 32'h40;
    step();
    redir_pc = 32'h80;
    step();
    redir = 1'b0;
    @(negedge clk);
    check("dbl_req_vld", bus.imem_req_valid, 1);
    check("dbl_imem_addr", bus.imem_addr, 32'h80);
    repeat (12) step();
    first = (pop_hist.size() > p0) ? pop_hist[p0] : 32'hFFFF_FFFF;
    check("dbl_first_pc", first, 32'h80);
    bad = 0;
    for (int k = p0; k < pop_hist.size(); k++)
      if (pop_hist[k] >= 32'h40 && pop_hist[k] < 32'h80) bad++;
    check("dbl_stale_pcs", bad, 0);

`ifdef ARM_PREFETCH_ABORT_EN
    // Errored fetch: abort reaches decode with its PC, fetch stops until redirect
    err_addr = 32'h108;
    do_reset(1);
    bus.inst_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_pc == 32'h108) found = 1;
    end
    check("abort_seen", found, 1);
    check("abort_flag", bus.inst_abort, 1);
    step();
    r0 = n_req;
    repeat (6) step();
    check("abort_no_req", n_req - r0, 0);
    redir = 1'b1; redir_pc = 32'h200;
    step();
    redir = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("abort_resume_vld", bus.imem_req_valid, 1);
    check("abort_resume_addr", bus.imem_addr, 32'h200);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
